swervolf_uart_mux: RTL and testbench

SWERVOLF_UART_MUX -- requirements
Module: swervolf_uart_mux

---
 rtl/swervolf_uart_mux_pkg.sv | 19 +
 rtl/swervolf_uart_mux_if.sv | 15 +
 rtl/swervolf_uart_idle_det.sv | 46 ++++
 rtl/swervolf_uart_mux.sv | 90 +++++++++
 tb/tb_swervolf_uart_mux.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/swervolf_uart_mux_pkg.sv
// Shared definitions for the SweRVolf UART source multiplexer: FSM encodings,
// idle-counter sizing and the select-width helper.
package swervolf_uart_mux_pkg;

  // 25 MHz / 115200 baud is about 217 clk per bit, so a 10-bit frame is about 2170 clk.
  // 2400 is a little longer than one whole frame.
  localparam int unsigned DEFAULT_IDLE_CYCLES = 2400;
  localparam int unsigned CNT_W = 16;

  typedef logic [1:0] mux_state_t;
  localparam mux_state_t ST_ACTIVE = 2'd0;
  localparam mux_state_t ST_DRAIN  = 2'd1;
  localparam mux_state_t ST_HOLD   = 2'd2;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/swervolf_uart_mux_if.sv
// Source-side and pin-side signals of the UART mux, bundled for the mux port.
interface swervolf_uart_mux_if #(
  parameter int N_CH = 2,
  parameter int SELW = swervolf_uart_mux_pkg::sel_width(N_CH)
);
  logic [N_CH-1:0] i_tx;
  logic [SELW-1:0] i_sel;
  logic            o_tx;
  logic [SELW-1:0] o_sel;
  logic            o_switching;
  logic [N_CH-1:0] o_idle;

  modport master (output i_tx, i_sel, input o_tx, o_sel, o_switching, o_idle);
  modport slave  (input i_tx, i_sel, output o_tx, o_sel, o_switching, o_idle);
endinterface

// File: rtl/swervolf_uart_idle_det.sv
// One TX line: 2-flop synchroniser plus a saturating count of consecutive mark
// cycles; the line is idle once the count reaches IDLE_CYCLES.
module swervolf_uart_idle_det
  import swervolf_uart_mux_pkg::*;
#(
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic tx_i,
  output logic line_o,
  output logic idle_o
);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronisers reset to mark so an undriven line looks like an idle UART.
  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= tx_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: next-state logic assigns a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != IDLE_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign line_o = sync2_q;
  assign idle_o = (cnt_q == IDLE_MAX);

endmodule

// File: rtl/swervolf_uart_mux.sv
// Forwards one of N_CH UART TX lines to the pin and changes source only at
// frame boundaries: drain the old channel to idle, then wait for the new one to be idle.
module swervolf_uart_mux
  import swervolf_uart_mux_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int DEFAULT_CH  = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  swervolf_uart_mux_if.slave   bus
);
  localparam int SELW  = sel_width(N_CH);
  localparam int SELW1 = SELW + 1;
  localparam logic [SELW-1:0] DEF_SEL = SELW'(DEFAULT_CH);
  localparam logic [SELW:0]   N_CH_L  = SELW1'(N_CH);

  logic [N_CH-1:0] line_s, idle_s;
  logic [SELW-1:0] sel1_q, sel2_q, req_q, req_d;
  logic [SELW-1:0] cur_q, cur_d;
  mux_state_t      state_q, state_d;
  logic            tx_q, tx_d;
  logic            cur_line, cur_idle;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    swervolf_uart_idle_det #(.IDLE_CYCLES(IDLE_CYCLES)) u_idle_det (
      .clk   (clk),
      .rstn  (rstn),
      .tx_i  (bus.i_tx[i]),
      .line_o(line_s[i]),
      .idle_o(idle_s[i])
    );
  end

  assign cur_line = line_s[cur_q];
  assign cur_idle = idle_s[cur_q];

  // Out-of-range switch settings leave the previous request in place.
  always_comb begin
    req_d = req_q;
    if ({1'b0, sel2_q} < N_CH_L) begin
      req_d = sel2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      ST_ACTIVE: if (req_q != cur_q) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (req_q == cur_q) begin
          state_d = ST_ACTIVE;
        end else if (cur_idle) begin
          state_d = ST_HOLD;
          cur_d   = req_q;
        end
      end
      ST_HOLD:   if (cur_idle) state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
    // While waiting for the new source to go quiet the pin shows mark.
    tx_d = (state_d == ST_HOLD) ? 1'b1 : cur_line;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel1_q  <= DEF_SEL;
      sel2_q  <= DEF_SEL;
      req_q   <= DEF_SEL;
      cur_q   <= DEF_SEL;
      state_q <= ST_ACTIVE;
      tx_q    <= 1'b1;
    end else begin
      sel1_q  <= bus.i_sel;
      sel2_q  <= sel1_q;
      req_q   <= req_d;
      cur_q   <= cur_d;
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.o_tx        = tx_q;
  assign bus.o_sel       = cur_q;
  assign bus.o_switching = (state_q != ST_ACTIVE);
  assign bus.o_idle      = idle_s;

endmodule

// File: tb/tb_swervolf_uart_mux.sv
// Scoreboard bench: a history-based model of line idleness and source switching
// predicts every cycle's outputs; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_swervolf_uart_mux;
  localparam int N_CH = 4;
  localparam int SELW = 2;
  localparam int IDLE = 20;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  swervolf_uart_mux_if #(.N_CH(N_CH), .SELW(SELW)) bus ();
  swervolf_uart_mux #(.N_CH(N_CH), .IDLE_CYCLES(IDLE), .DEFAULT_CH(0)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Three-source instance: select value 3 is out of range and must be ignored.
  swervolf_uart_mux_if #(.N_CH(3), .SELW(2)) bus3 ();
  swervolf_uart_mux #(.N_CH(3), .IDLE_CYCLES(IDLE), .DEFAULT_CH(0)) dut3 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus3)
  );

  typedef struct packed {
    logic            tx;
    logic [SELW-1:0] sel;
    logic            sw;
    logic [N_CH-1:0] idle;
  } exp_t;
  typedef enum {M_FWD, M_WAIT_OLD, M_WAIT_NEW} mode_e;

  exp_t            exp_q[$];
  int              checks = 0;
  int              failures = 0;
  logic [N_CH-1:0] xh[$];    // xh[k+2] = i_tx driven after edge k (k = -2, -1 are mark)
  int              selh[$];  // selh[k+2] = i_sel driven after edge k
  int              edge_n;
  mode_e           mode;
  int              cur, req;
  logic            sw_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // A line is idle after edge e when its last IDLE synchronised samples were all mark
  // and at least IDLE edges have passed since reset.
  function automatic bit idle_at(input int e, input int ch);
    logic [N_CH-1:0] v;
    if (e < IDLE) return 1'b0;
    for (int k = e - 2 - IDLE; k <= e - 3; k++) begin
      v = xh[k + 2];
      if (!v[ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset(input logic [N_CH-1:0] tx0, input int sel0);
    xh.delete();
    selh.delete();
    xh.push_back('1);
    xh.push_back('1);
    xh.push_back(tx0);
    selh.push_back(0);
    selh.push_back(0);
    selh.push_back(sel0);
    edge_n = 0;
    mode   = M_FWD;
    cur    = 0;
    req    = 0;
  endtask

  // Predict the outputs just after edge edge_n from the stimulus history.
  task automatic model_edge();
    exp_t            e;
    logic [N_CH-1:0] v;
    bit              old_line, old_idle;
    int              s;
    edge_n++;
    v        = xh[edge_n - 1];             // line seen by the mux = input 3 cycles back
    old_line = v[cur];
    old_idle = idle_at(edge_n - 1, cur);
    case (mode)
      M_FWD:      if (req != cur) mode = M_WAIT_OLD;
      M_WAIT_OLD: begin
        if (req == cur) mode = M_FWD;
        else if (old_idle) begin
          mode = M_WAIT_NEW;
          cur  = req;
        end
      end
      M_WAIT_NEW: if (old_idle) mode = M_FWD;
      default:    mode = M_FWD;
    endcase
    s = selh[edge_n - 1];
    if (s < N_CH) req = s;
    e.tx  = (mode == M_WAIT_NEW) ? 1'b1 : old_line;
    e.sel = SELW'(cur);
    e.sw  = (mode != M_FWD);
    for (int ch = 0; ch < N_CH; ch++) e.idle[ch] = idle_at(edge_n, ch);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N_CH-1:0] tx, input int sel);
    @(posedge clk);
    #1;
    model_edge();
    bus.i_tx  = tx;
    bus.i_sel = SELW'(sel);
    xh.push_back(tx);
    selh.push_back(sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn      = 1'b0;
    bus.i_tx  = '1;
    bus.i_sel = '0;
    #2;
    check("reset o_tx", 32'(bus.o_tx), 32'd1);
    check("reset o_sel", 32'(bus.o_sel), 32'd0);
    check("reset o_switching", 32'(bus.o_switching), 32'd0);
    check("reset o_idle", 32'(bus.o_idle), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset('1, 0);
  endtask

  // Monitor: one prediction per clock while the model is running.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (bus.o_switching === 1'b1) sw_seen = 1'b1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.o_tx, bus.o_sel, bus.o_switching, bus.o_idle};
        check("scoreboard {tx,sel,sw,idle}", 32'(got), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N_CH-1:0] r, burst, tx;
    int              sel;
    bus.i_tx   = '1;
    bus.i_sel  = '0;
    bus3.i_tx  = '1;
    bus3.i_sel = '0;
    do_reset();

    repeat (25) step('1, 0);

    // Channel 0 pattern 0,1,0 on the forwarded source, other lines random.
    for (int i = 0; i < 24; i++) begin
      r = N_CH'($urandom);
      step({r[3:1], (i % 3 == 1)}, 0);
    end
    @(negedge clk); #1;
    check("fwd o_sel", 32'(bus.o_sel), 32'd0);
    check("fwd o_switching", 32'(bus.o_switching), 32'd0);

    // Request channel 2 while channel 0 is mid-transmission.
    for (int i = 0; i < 30; i++) begin
      r = N_CH'($urandom);
      step({r[3], 1'b1, r[1], 1'b0}, 2);
    end
    for (int i = 0; i < 40; i++) begin
      r = N_CH'($urandom);
      step({r[3], 1'b1, r[1], 1'b1}, 2);
    end
    @(negedge clk); #1;
    check("switch o_sel", 32'(bus.o_sel), 32'd2);
    check("switch o_switching", 32'(bus.o_switching), 32'd0);

    // Out-of-range select on the three-source instance.
    bus3.i_sel = 2'd3;
    for (int i = 0; i < 20; i++) step(N_CH'($urandom), 2);
    @(negedge clk); #1;
    check("ignore o_sel", 32'(bus3.o_sel), 32'd0);
    check("ignore o_switching", 32'(bus3.o_switching), 32'd0);
    bus3.i_sel = 2'd2;
    for (int i = 0; i < 10; i++) step(N_CH'($urandom), 2);
    bus3.i_sel = 2'd3;
    for (int i = 0; i < 10; i++) step(N_CH'($urandom), 2);
    @(negedge clk); #1;
    check("ignore keeps o_sel", 32'(bus3.o_sel), 32'd2);
    check("ignore keeps o_switching", 32'(bus3.o_switching), 32'd0);

    // Back to channel 0, then a short 0->1->0 request while channel 0 is busy.
    repeat (50) step('1, 0);
    @(negedge clk); #1;
    check("return o_sel", 32'(bus.o_sel), 32'd0);
    sw_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      r = N_CH'($urandom);
      step({r[3:1], 1'b0}, (i >= 3 && i < 9) ? 1 : 0);
    end
    @(negedge clk); #1;
    check("abort pulse seen", 32'(sw_seen), 32'd1);
    check("abort o_sel", 32'(bus.o_sel), 32'd0);
    check("abort o_switching", 32'(bus.o_switching), 32'd0);

    // Channel 3 never goes quiet, so the mux waits with the pin at mark.
    for (int i = 0; i < 60; i++) begin
      r = N_CH'($urandom);
      step({((i / 5) % 2 == 1), r[2:1], 1'b1}, 3);
    end
    @(negedge clk); #1;
    check("stuck o_tx", 32'(bus.o_tx), 32'd1);
    check("stuck o_switching", 32'(bus.o_switching), 32'd1);
    check("stuck o_sel", 32'(bus.o_sel), 32'd3);

    // Reset while waiting: the checks inside do_reset happen before any clock edge.
    do_reset();

    burst = '0;
    sel   = 0;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 99) < 4) burst[ch] = ~burst[ch];
        tx[ch] = burst[ch] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if ($urandom_range(0, 99) < 3) sel = $urandom_range(0, N_CH - 1);
      step(tx, sel);
    end

    @(negedge clk); #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
